// File: rtl/lab1_imul_pkg.sv
// rtl/lab1_imul_pkg.sv - shared types and constants for the imul pow requester
//
// Purpose: FSM state encoding, default widths and multiply-request message
//          layout used by the pow requester top and its datapath.
// Ports:   none (package).
package lab1_imul_pkg;

  // Default operand/result width and exponent width.
  localparam int unsigned POW_NBITS = 32;
  localparam int unsigned POW_EBITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } pow_state_e;

  // mul_req_msg layout: operand a in the upper half, operand b in the lower half.
  localparam int unsigned MUL_B_LSB = 0;

  function automatic int unsigned mul_a_lsb(input int unsigned nbits);
    return nbits;
  endfunction

endpackage

// File: rtl/lab1_imul_pow_requester_dpath.sv
// rtl/lab1_imul_pow_requester_dpath.sv - operand, accumulator and count registers
//
// Purpose: holds the job base, the running product and the remaining multiply
//          count; reports the status bits the control FSM branches on.
// Ports:   clk, reset (async active-low)
//          job_go, resp_go      load strobes from the control FSM
//          job_base, job_exp    incoming job operands
//          mul_resp_msg         product returned by the multiplier
//          base_reg, acc        registered operands for the next multiply
//          cnt_is_one           last outstanding multiply
//          exp_is_zero          incoming job needs no multiplies
module lab1_imul_pow_requester_dpath
  import lab1_imul_pkg::*;
#(
  parameter int unsigned p_nbits = POW_NBITS,
  parameter int unsigned p_ebits = POW_EBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               job_go,
  input  logic               resp_go,
  input  logic [p_nbits-1:0] job_base,
  input  logic [p_ebits-1:0] job_exp,
  input  logic [p_nbits-1:0] mul_resp_msg,
  output logic [p_nbits-1:0] base_reg,
  output logic [p_nbits-1:0] acc,
  output logic               cnt_is_one,
  output logic               exp_is_zero
);

  localparam logic [p_nbits-1:0] ACC_ONE = p_nbits'(1);
  localparam logic [p_ebits-1:0] CNT_ONE = p_ebits'(1);

  logic [p_ebits-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_reg <= '0;
      acc      <= ACC_ONE;
      cnt      <= '0;
    end else if (job_go) begin
      base_reg <= job_base;
      acc      <= ACC_ONE;
      cnt      <= job_exp;
    end else if (resp_go) begin
      // The FSM only accepts a response while cnt >= 1, so this never wraps.
      acc <= mul_resp_msg;
      cnt <= cnt - CNT_ONE;
    end
  end

  assign cnt_is_one  = (cnt == CNT_ONE);
  assign exp_is_zero = (job_exp == '0);

endmodule

// File: rtl/lab1_imul_pow_requester.sv
// rtl/lab1_imul_pow_requester.sv - base**exp via a chain of external multiplies
//
// Purpose: accepts a (base, exp) job, issues exp dependent multiply requests
//          {acc, base} to an external val/rdy multiplier with one in flight,
//          and returns base**exp mod 2^p_nbits.
// Ports:   clk, reset (async active-low)
//          job_val/job_rdy/job_base/job_exp              job request channel
//          res_val/res_rdy/res_msg                       result channel
//          mul_req_val/mul_req_rdy/mul_req_msg           multiply request channel
//          mul_resp_val/mul_resp_rdy/mul_resp_msg        multiply response channel
module lab1_imul_pow_requester
  import lab1_imul_pkg::*;
#(
  parameter int unsigned p_nbits = POW_NBITS,
  parameter int unsigned p_ebits = POW_EBITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 job_val,
  output logic                 job_rdy,
  input  logic [p_nbits-1:0]   job_base,
  input  logic [p_ebits-1:0]   job_exp,
  output logic                 res_val,
  input  logic                 res_rdy,
  output logic [p_nbits-1:0]   res_msg,
  output logic                 mul_req_val,
  input  logic                 mul_req_rdy,
  output logic [2*p_nbits-1:0] mul_req_msg,
  input  logic                 mul_resp_val,
  output logic                 mul_resp_rdy,
  input  logic [p_nbits-1:0]   mul_resp_msg
);

  localparam int unsigned A_LSB = mul_a_lsb(p_nbits);

  pow_state_e         state_r;
  pow_state_e         state_n;
  logic [p_nbits-1:0] base_reg;
  logic [p_nbits-1:0] acc;
  logic               cnt_is_one;
  logic               exp_is_zero;
  logic               job_go;
  logic               resp_go;

  assign job_go  = job_val && job_rdy;
  assign resp_go = mul_resp_val && mul_resp_rdy;

  lab1_imul_pow_requester_dpath #(
    .p_nbits (p_nbits),
    .p_ebits (p_ebits)
  ) u_dpath (
    .clk          (clk),
    .reset        (reset),
    .job_go       (job_go),
    .resp_go      (resp_go),
    .job_base     (job_base),
    .job_exp      (job_exp),
    .mul_resp_msg (mul_resp_msg),
    .base_reg     (base_reg),
    .acc          (acc),
    .cnt_is_one   (cnt_is_one),
    .exp_is_zero  (exp_is_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Control-signal table. Each state raises exactly one ready/valid, so a
  // second multiply can never be issued while one is outstanding.
  always_comb begin
    state_n      = state_r;
    job_rdy      = 1'b0;
    res_val      = 1'b0;
    res_msg      = acc;
    mul_req_val  = 1'b0;
    mul_req_msg  = '0;
    mul_req_msg[A_LSB +: p_nbits]     = acc;
    mul_req_msg[MUL_B_LSB +: p_nbits] = base_reg;
    mul_resp_rdy = 1'b0;
    case (state_r)
      IDLE: begin
        // Held low while reset is asserted; ready only once reset releases.
        job_rdy = reset;
        if (job_val) begin
          state_n = exp_is_zero ? DONE : SEND;
        end
      end
      SEND: begin
        mul_req_val = 1'b1;
        if (mul_req_rdy) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        mul_resp_rdy = 1'b1;
        if (mul_resp_val) begin
          state_n = cnt_is_one ? DONE : SEND;
        end
      end
      DONE: begin
        res_val = 1'b1;
        if (res_rdy) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n      = IDLE;
        job_rdy      = 1'bx;
        res_val      = 1'bx;
        res_msg      = 'x;
        mul_req_val  = 1'bx;
        mul_req_msg  = 'x;
        mul_resp_rdy = 1'bx;
      end
    endcase
  end

endmodule
